// File: rtl/ucode_pkg.sv
// Shared types and helpers for the microcode sequencer.
// Holds the state encoding, the default NOP word and the length-field extractor.
package ucode_pkg;

  typedef enum logic {StIdle = 1'b0, StSeq = 1'b1} state_e;

  localparam logic [63:0] NOP_DEFAULT = '0;

  // Length loads carry L in the low dw bits of the data word.
  function automatic logic [63:0] len_field(input logic [63:0] data, input int unsigned dw);
    logic [63:0] mask;
    mask = (64'd1 << dw) - 64'd1;
    return data & mask;
  endfunction

endpackage

// File: rtl/ucode_seq_if.sv
// Decode-side bundle of the microcode sequencer: fetch/trap/control inputs, load port, issue outputs.
interface ucode_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RW    = 2,
  parameter int unsigned DW    = 3
);
  logic [WIDTH-1:0] fetch_inst;
  logic             trap_valid;
  logic [RW-1:0]    trap_id;
  logic             stall;
  logic             flush;
  logic             ld_we;
  logic             ld_len;
  logic [RW-1:0]    ld_rid;
  logic [DW-1:0]    ld_idx;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] inst_out;
  logic             pc_ce;
  logic             busy;
  logic [DW-1:0]    uop_idx;
  logic             done;
  logic             err;

  modport master (
    output fetch_inst, trap_valid, trap_id, stall, flush,
    output ld_we, ld_len, ld_rid, ld_idx, ld_data,
    input  inst_out, pc_ce, busy, uop_idx, done, err
  );

  modport slave (
    input  fetch_inst, trap_valid, trap_id, stall, flush,
    input  ld_we, ld_len, ld_rid, ld_idx, ld_data,
    output inst_out, pc_ce, busy, uop_idx, done, err
  );
endinterface

// File: rtl/ucode_store.sv
// Microcode word array and per-routine length registers.
// One synchronous write port, one asynchronous read port; contents are not reset.
module ucode_store
  import ucode_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_ROUTINES = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RW           = $clog2(NUM_ROUTINES),
  parameter int unsigned DW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_len,
  input  logic [RW-1:0]    i_rid,
  input  logic [DW-1:0]    i_idx,
  input  logic [WIDTH-1:0] i_data,
  input  logic [RW-1:0]    i_rd_rid,
  input  logic [DW-1:0]    i_rd_idx,
  output logic [WIDTH-1:0] o_rd_word,
  output logic [DW-1:0]    o_rd_len
);

  logic [WIDTH-1:0] r_mem [NUM_ROUTINES][DEPTH];
  logic [DW-1:0]    r_len [NUM_ROUTINES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_len) begin
        r_len[i_rid] <= DW'(len_field(64'(i_data), DW));
      end else begin
        r_mem[i_rid][i_idx] <= i_data;
      end
    end
  end

  assign o_rd_word = r_mem[i_rd_rid][i_rd_idx];
  assign o_rd_len  = r_len[i_rd_rid];

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: on a trap, freezes the PC and issues the stored words of the
// selected routine one per non-stalled cycle, then hands issue back to the fetch path.
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      NUM_ROUTINES = 4,
  parameter int unsigned      DEPTH        = 8,
  parameter logic [WIDTH-1:0] NOP_WORD     = NOP_DEFAULT[WIDTH-1:0]
) (
  input logic       clk,
  input logic       rst,
  ucode_seq_if.slave bus
);

  localparam int unsigned RW = $clog2(NUM_ROUTINES);
  localparam int unsigned DW = $clog2(DEPTH);

  state_e        r_state;
  logic [RW-1:0] r_rid;
  logic [DW-1:0] r_idx;
  logic          r_err;

  logic             w_trigger;
  logic             w_ld_ok;
  logic [WIDTH-1:0] w_word;
  logic [DW-1:0]    w_len;

  assign w_trigger = (r_state == StIdle) && bus.trap_valid && !bus.stall && !bus.flush;
  // Loads may only land while idle and not in the cycle that starts a routine.
  assign w_ld_ok   = bus.ld_we && (r_state == StIdle) && !w_trigger;

  ucode_store #(
    .WIDTH        (WIDTH),
    .NUM_ROUTINES (NUM_ROUTINES),
    .DEPTH        (DEPTH),
    .RW           (RW),
    .DW           (DW)
  ) u_store (
    .clk       (clk),
    .i_we      (w_ld_ok),
    .i_len     (bus.ld_len),
    .i_rid     (bus.ld_rid),
    .i_idx     (bus.ld_idx),
    .i_data    (bus.ld_data),
    .i_rd_rid  (r_rid),
    .i_rd_idx  (r_idx),
    .o_rd_word (w_word),
    .o_rd_len  (w_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_rid   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (bus.ld_we && !w_ld_ok) || ((r_state == StSeq) && bus.trap_valid);
      unique case (r_state)
        StIdle: begin
          if (w_trigger) begin
            r_rid   <= bus.trap_id;
            r_idx   <= '0;
            r_state <= StSeq;
          end
        end
        StSeq: begin
          if (bus.flush) begin
            r_idx   <= '0;
            r_state <= StIdle;
          end else if (!bus.stall) begin
            if (r_idx == w_len) begin
              r_idx   <= '0;
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + DW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.inst_out = bus.fetch_inst;
    bus.pc_ce    = !bus.stall;
    bus.busy     = 1'b0;
    bus.uop_idx  = '0;
    bus.done     = 1'b0;
    if (r_state == StSeq) begin
      bus.inst_out = bus.flush ? NOP_WORD : w_word;
      bus.pc_ce    = 1'b0;
      bus.busy     = 1'b1;
      bus.uop_idx  = r_idx;
      bus.done     = !bus.flush && !bus.stall && (r_idx == w_len);
    end
  end

  assign bus.err = r_err;

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: routine issue, stalls, flush, nested trap/load rejection, reset.
module tb_ucode_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RW    = 2;
  localparam int unsigned DW    = 3;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] FETCH = 32'hF00D_0001;
  localparam logic [31:0] A0    = 32'hA000_00A0;
  localparam logic [31:0] A1    = 32'hA000_00A1;
  localparam logic [31:0] A2    = 32'hA000_00A2;
  localparam logic [31:0] B0    = 32'hB000_00B0;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ucode_seq_if #(.WIDTH(WIDTH), .RW(RW), .DW(DW)) bus ();

  ucode_seq #(
    .WIDTH        (WIDTH),
    .NUM_ROUTINES (4),
    .DEPTH        (8),
    .NOP_WORD     (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: inputs change on the falling edge, outputs are sampled 1ns later.
  task automatic cyc(input logic tv, input logic [RW-1:0] tid, input logic st, input logic fl);
    @(negedge clk);
    bus.trap_valid = tv;
    bus.trap_id    = tid;
    bus.stall      = st;
    bus.flush      = fl;
    bus.ld_we      = 1'b0;
    #1;
  endtask

  task automatic load(input logic len, input logic [RW-1:0] rid, input logic [DW-1:0] idx,
                      input logic [31:0] d);
    @(negedge clk);
    bus.trap_valid = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.ld_we      = 1'b1;
    bus.ld_len     = len;
    bus.ld_rid     = rid;
    bus.ld_idx     = idx;
    bus.ld_data    = d;
    @(negedge clk);
    bus.ld_we = 1'b0;
    #1;
    check("load_err", 64'(bus.err), 64'd0);
  endtask

  task automatic exp_seq(input string tag, input logic [31:0] w, input logic [DW-1:0] idx,
                         input logic dn);
    check({tag, "_inst"}, 64'(bus.inst_out), 64'(w));
    check({tag, "_idx"},  64'(bus.uop_idx),  64'(idx));
    check({tag, "_busy"}, 64'(bus.busy),     64'd1);
    check({tag, "_pcce"}, 64'(bus.pc_ce),    64'd0);
    check({tag, "_done"}, 64'(bus.done),     64'(dn));
  endtask

  task automatic exp_idle(input string tag);
    check({tag, "_inst"}, 64'(bus.inst_out), 64'(FETCH));
    check({tag, "_idx"},  64'(bus.uop_idx),  64'd0);
    check({tag, "_busy"}, 64'(bus.busy),     64'd0);
    check({tag, "_pcce"}, 64'(bus.pc_ce),    64'd1);
    check({tag, "_done"}, 64'(bus.done),     64'd0);
  endtask

  task automatic exp_trigger(input string tag);
    check({tag, "_pcce"}, 64'(bus.pc_ce),    64'd1);
    check({tag, "_busy"}, 64'(bus.busy),     64'd0);
    check({tag, "_inst"}, 64'(bus.inst_out), 64'(FETCH));
  endtask

  task automatic run_a(input string tag);
    cyc(1'b1, 2'd1, 1'b0, 1'b0); exp_trigger({tag, "_trig"});
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq({tag, "_a0"}, A0, 3'd0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq({tag, "_a1"}, A1, 3'd1, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq({tag, "_a2"}, A2, 3'd2, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle({tag, "_end"});
  endtask

  initial begin
    logic [31:0] st_words [5];
    logic        st_pat   [6];
    int          n_busy;
    int          n_done;

    rst            = 1'b0;
    bus.fetch_inst = FETCH;
    bus.trap_valid = 1'b0;
    bus.trap_id    = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.ld_we      = 1'b0;
    bus.ld_len     = 1'b0;
    bus.ld_rid     = '0;
    bus.ld_idx     = '0;
    bus.ld_data    = '0;
    repeat (3) @(negedge clk);
    #1;
    exp_idle("rst");
    check("rst_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    load(1'b0, 2'd1, 3'd0, A0);
    load(1'b0, 2'd1, 3'd1, A1);
    load(1'b0, 2'd1, 3'd2, A2);
    load(1'b1, 2'd1, 3'd0, 32'hFFFF_FFF2);  // upper bits ignored, L = 2
    load(1'b0, 2'd3, 3'd0, B0);
    load(1'b1, 2'd3, 3'd0, 32'h0000_0000);

    // Trap while stalled in IDLE must not start a routine.
    cyc(1'b1, 2'd1, 1'b1, 1'b0);
    check("idle_stall_pcce", 64'(bus.pc_ce), 64'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    exp_idle("idle_stall_next");

    run_a("basic");

    // Stall on the A1 cycle for two cycles.
    st_words = '{A0, A1, A1, A1, A2};
    st_pat   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    n_busy   = 0;
    n_done   = 0;
    cyc(1'b1, 2'd1, 1'b0, 1'b0); exp_trigger("stl_trig");
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'd0, st_pat[i], 1'b0);
      if (bus.busy) n_busy++;
      if (bus.done) n_done++;
      if (i < 5) check($sformatf("stl_inst%0d", i), 64'(bus.inst_out), 64'(st_words[i]));
    end
    check("stl_busy_cycles", 64'(n_busy), 64'd5);
    check("stl_done_pulses", 64'(n_done), 64'd1);

    // Single-word routine.
    cyc(1'b1, 2'd3, 1'b0, 1'b0); exp_trigger("one_trig");
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("one_b0", B0, 3'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle("one_end");

    // Flush during A1 (stall also high: flush wins), then retrigger.
    cyc(1'b1, 2'd1, 1'b0, 1'b0); exp_trigger("fl_trig");
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("fl_a0", A0, 3'd0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b1);
    check("fl_inst", 64'(bus.inst_out), 64'(NOP));
    check("fl_done", 64'(bus.done), 64'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle("fl_after");
    run_a("refl");

    // Nested trap and load during SEQ are rejected.
    cyc(1'b1, 2'd1, 1'b0, 1'b0); exp_trigger("nest_trig");
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    bus.ld_we   = 1'b1;
    bus.ld_len  = 1'b0;
    bus.ld_rid  = 2'd1;
    bus.ld_idx  = 3'd1;
    bus.ld_data = 32'hDEAD_BEEF;
    exp_seq("nest_a0", A0, 3'd0, 1'b0);
    check("nest_err0", 64'(bus.err), 64'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("nest_a1", A1, 3'd1, 1'b0);
    check("nest_err1", 64'(bus.err), 64'd1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("nest_a2", A2, 3'd2, 1'b1);
    check("nest_err2", 64'(bus.err), 64'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle("nest_end");

    // Load coinciding with a trigger is dropped.
    @(negedge clk);
    bus.trap_valid = 1'b1;
    bus.trap_id    = 2'd1;
    bus.ld_we      = 1'b1;
    bus.ld_rid     = 2'd3;
    bus.ld_idx     = 3'd0;
    bus.ld_data    = 32'hDEAD_BEEF;
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("tl_a0", A0, 3'd0, 1'b0);
    check("tl_err", 64'(bus.err), 64'd1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("tl_a1", A1, 3'd1, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("tl_a2", A2, 3'd2, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle("tl_end");

    // Reset during A1 abandons the routine at once; storage survives.
    cyc(1'b1, 2'd1, 1'b0, 1'b0); exp_trigger("rs_trig");
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("rs_a0", A0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_idle("rs_now");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_a("rs_again");
    cyc(1'b1, 2'd3, 1'b0, 1'b0); exp_trigger("rs_b_trig");
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_seq("rs_b0", B0, 3'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0); exp_idle("rs_b_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
